// File: rtl/avmm_pio_bank_pkg.sv
// pio_bank_pkg: shared definitions for the Avalon-MM PIO bank.
//   - register offsets within a channel's 4-word window
//   - edge capture mode enum
//   - width helpers for the address bus and the debounce counter
package pio_bank_pkg;

  localparam logic [1:0] REG_DATA_IN  = 2'd0;
  localparam logic [1:0] REG_DATA_OUT = 2'd1;
  localparam logic [1:0] REG_EDGE_CAP = 2'd2;
  localparam logic [1:0] REG_IRQ_MASK = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  // Word address width: channel index bits plus two register-select bits.
  function automatic int unsigned addr_w(input int unsigned num_ch);
    return $clog2(num_ch) + 2;
  endfunction

  // Debounce counter width; must hold the value DEBOUNCE_CYCLES itself.
  function automatic int unsigned cnt_w(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/avmm_pio_bank_debounce.sv
// pio_debounce: one PIO channel's input path.
//   clk, reset_n : clock, async active-low reset
//   pio_in       : raw asynchronous input word
//   deb          : synchronised, debounced word (DATA_IN)
//   edge_evt     : one-clock pulse per bit, valid in the cycle before deb
//                  changes in the direction selected by EDGE_MODE
module pio_debounce
  import pio_bank_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_MODE       = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pio_in,
  output logic [DATA_W-1:0] deb,
  output logic [DATA_W-1:0] edge_evt
);

  localparam edge_mode_e MODE = edge_mode_e'(2'(EDGE_MODE));

  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] deb_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
    end else begin
      s1  <= pio_in;
      s2  <= s1;
      deb <= deb_nxt;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
    assign deb_nxt = s2;
  end else begin : g_deb
    localparam int unsigned     CNT_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic [DATA_W-1:0] s2_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  run;

    // run = number of consecutive clocks s2 has shown its current value,
    // including this one. The count only advances while s2 differs from
    // deb, and deb takes s2 on the clock the run reaches DEBOUNCE_CYCLES.
    always_comb begin
      deb_nxt = deb;
      cnt_nxt = '0;
      run     = (s2 != s2_d) ? CNT_W'(1) : cnt + CNT_W'(1);
      if (s2 != deb) begin
        if (run == CNT_LAST) begin
          deb_nxt = s2;
        end else begin
          cnt_nxt = run;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_d <= '0;
        cnt  <= '0;
      end else begin
        s2_d <= s2;
        cnt  <= cnt_nxt;
      end
    end
  end

  // Computed from deb_nxt so the capture register sets on the same edge
  // that deb changes.
  always_comb begin
    edge_evt = '0;
    case (MODE)
      EDGE_RISE: edge_evt = deb_nxt & ~deb;
      EDGE_FALL: edge_evt = ~deb_nxt & deb;
      default:   edge_evt = deb_nxt ^ deb;
    endcase
  end

endmodule

// File: rtl/avmm_pio_bank.sv
// avmm_pio_bank: bank of NUM_CH parallel I/O channels on an Avalon-MM slave.
//   clk, reset_n     : clock, async active-low reset
//   avs_address      : {channel, reg[1:0]} word address
//   avs_read/write   : strobes; fixed read latency of 1, no waitrequest
//   avs_writedata    : write data (bits above DATA_W ignored)
//   avs_readdata     : registered read data, zero-extended
//   irq              : level interrupt, OR of (EDGE_CAP & IRQ_MASK) over channels
//   pio_in / pio_out : packed channel words, channel c at [c*DATA_W +: DATA_W]
module avmm_pio_bank
  import pio_bank_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_MODE       = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [addr_w(NUM_CH)-1:0]  avs_address,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [31:0]                avs_writedata,
  output logic [31:0]                avs_readdata,
  output logic                       irq,
  input  logic [NUM_CH*DATA_W-1:0]   pio_in,
  output logic [NUM_CH*DATA_W-1:0]   pio_out
);

  logic [DATA_W-1:0] data_out [NUM_CH];
  logic [DATA_W-1:0] edge_cap [NUM_CH];
  logic [DATA_W-1:0] irq_mask [NUM_CH];
  logic [DATA_W-1:0] deb      [NUM_CH];
  logic [DATA_W-1:0] edge_evt [NUM_CH];
  logic [DATA_W-1:0] edge_clr [NUM_CH];

  int unsigned       ch_sel;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_word;

  assign ch_sel  = 32'(avs_address >> 2);
  assign reg_sel = avs_address[1:0];
  assign wdata   = avs_writedata[DATA_W-1:0];

  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
    pio_debounce #(
      .DATA_W          (DATA_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .pio_in   (pio_in[c*DATA_W +: DATA_W]),
      .deb      (deb[c]),
      .edge_evt (edge_evt[c])
    );

    assign pio_out[c*DATA_W +: DATA_W] = data_out[c];
  end

  // Out-of-range channels never match ch_sel, so their writes fall away
  // and their reads return the zero default.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      edge_clr[c] = (avs_write && ch_sel == c && reg_sel == REG_EDGE_CAP) ? wdata : '0;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_sel == c) begin
        case (reg_sel)
          REG_DATA_IN:  rd_word = deb[c];
          REG_DATA_OUT: rd_word = data_out[c];
          REG_EDGE_CAP: rd_word = edge_cap[c];
          default:      rd_word = irq_mask[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        data_out[c] <= '0;
        edge_cap[c] <= '0;
        irq_mask[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (avs_write && ch_sel == c) begin
          if (reg_sel == REG_DATA_OUT) data_out[c] <= wdata;
          if (reg_sel == REG_IRQ_MASK) irq_mask[c] <= wdata;
        end
        // Clear first, then OR in new edges: a same-cycle set wins.
        edge_cap[c] <= (edge_cap[c] & ~edge_clr[c]) | edge_evt[c];
      end
    end
  end

  // Registered read sees pre-write contents when read and write coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= 32'(rd_word);
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      irq = irq | (|(edge_cap[c] & irq_mask[c]));
    end
  end

endmodule

// File: tb/tb_avmm_pio_bank.sv
`timescale 1ns/1ps
module tb_avmm_pio_bank;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEB    = 4;
  localparam int unsigned EMODE  = 0;
  localparam int unsigned AW     = 4;
  localparam int unsigned PW     = NUM_CH * DATA_W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [PW-1:0] pio_in = '0;
  logic [PW-1:0] pio_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  avmm_pio_bank #(
    .NUM_CH          (NUM_CH),
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (DEB),
    .EDGE_MODE       (EMODE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pio_in        (pio_in),
    .pio_out       (pio_out)
  );

  // Reference model: register contents after each clock edge.
  // hist[c][k] = pio_in of channel c sampled k edges ago (k=0 is this edge);
  // the synchronised value seen at an edge is hist[2].
  logic [31:0] m_out  [NUM_CH];
  logic [31:0] m_cap  [NUM_CH];
  logic [31:0] m_mask [NUM_CH];
  logic [31:0] m_deb  [NUM_CH];
  logic [31:0] m_hist [NUM_CH][DEB+2];

  task automatic model_clear();
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      m_out[c] = '0; m_cap[c] = '0; m_mask[c] = '0; m_deb[c] = '0;
      for (int unsigned k = 0; k < DEB + 2; k++) m_hist[c][k] = '0;
    end
  endtask

  task automatic model_step();
    logic [31:0] nd;
    logic [31:0] edges;
    logic        stable;
    int unsigned ch;
    ch = 32'(avs_address) >> 2;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned k = DEB + 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = pio_in[c*DATA_W +: DATA_W];
      // New debounced value when the synchronised input has shown one
      // value for DEB consecutive clocks.
      stable = 1'b1;
      for (int unsigned k = 3; k <= DEB + 1; k++)
        if (m_hist[c][k] !== m_hist[c][2]) stable = 1'b0;
      nd = stable ? m_hist[c][2] : m_deb[c];
      case (EMODE)
        0:       edges = nd & ~m_deb[c];
        1:       edges = ~nd & m_deb[c];
        default: edges = nd ^ m_deb[c];
      endcase
      m_deb[c] = nd;
      if (avs_write && ch == c) begin
        case (avs_address[1:0])
          2'd1: m_out[c]  = avs_writedata;
          2'd2: m_cap[c]  = m_cap[c] & ~avs_writedata;
          2'd3: m_mask[c] = avs_writedata;
          default: ;
        endcase
      end
      m_cap[c] = m_cap[c] | edges;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int unsigned ch;
    ch = 32'(a) >> 2;
    if (ch >= NUM_CH) return '0;
    case (a[1:0])
      2'd0:    return m_deb[ch];
      2'd1:    return m_out[ch];
      2'd2:    return m_cap[ch];
      default: return m_mask[ch];
    endcase
  endfunction

  function automatic logic [PW-1:0] model_pio_out();
    logic [PW-1:0] v;
    for (int unsigned c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = m_out[c];
    return v;
  endfunction

  function automatic logic model_irq();
    logic v;
    v = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) v = v | (|(m_cap[c] & m_mask[c]));
    return v;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else model_step();
    end
  end

  // Monitor: pops one expected word per read accepted at the previous edge,
  // and checks pio_out / irq against the model every cycle.
  initial begin
    logic rd;
    forever begin
      @(posedge clk);
      rd = avs_read && reset_n;
      @(negedge clk);
      if (rd) begin
        if (exp_q.size() == 0) check("read_no_expect", PW'(1), PW'(0));
        else check("readdata", PW'(avs_readdata), PW'(exp_q.pop_front()));
      end
      check("pio_out", pio_out, model_pio_out());
      check("irq", PW'(irq), PW'(model_irq()));
    end
  end

  task automatic bus(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = a;
    avs_writedata = d;
    if (rd) exp_q.push_back(model_read(a));
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [1:0]    op;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_readdata", PW'(avs_readdata), '0);
    check("rst_pio_out", pio_out, '0);
    check("rst_irq", PW'(irq), '0);
    @(negedge clk);
    reset_n = 1'b1;

    // ch1 DATA_OUT write and read-back
    bus(1'b0, 1'b1, 4'd5, 32'h0000_00A5);
    idle();
    #1 check("ch1_pio_out", PW'(pio_out[63:32]), PW'(32'hA5));
    bus(1'b1, 1'b0, 4'd5, '0);
    idle();
    #1 check("ch1_readback", PW'(avs_readdata), PW'(32'hA5));

    // Debounce: 3-clock pulse rejected, 6-clock pulse accepted
    bus(1'b1, 1'b0, 4'd0, '0); pio_in[0] = 1'b1;
    repeat (2) bus(1'b1, 1'b0, 4'd0, '0);
    bus(1'b1, 1'b0, 4'd2, '0); pio_in[0] = 1'b0;
    for (int unsigned i = 0; i < 10; i++) bus(1'b1, 1'b0, AW'((i % 2) * 2), '0);
    bus(1'b1, 1'b0, 4'd0, '0); pio_in[0] = 1'b1;
    repeat (5) bus(1'b1, 1'b0, 4'd0, '0);
    bus(1'b1, 1'b0, 4'd2, '0); pio_in[0] = 1'b0;
    for (int unsigned i = 0; i < 12; i++) bus(1'b1, 1'b0, AW'((i % 2) * 2), '0);
    idle();
    #1 check("pulse6_edge_cap", PW'(avs_readdata), PW'(32'h1));

    // irq on ch2 rising edge, cleared by W1C
    bus(1'b0, 1'b1, 4'd11, 32'h1);
    idle(); pio_in[64] = 1'b1;
    repeat (8) idle();
    #1 check("ch2_irq_set", PW'(irq), PW'(1'b1));
    bus(1'b0, 1'b1, 4'd10, 32'h1);
    idle();
    #1 check("ch2_irq_clear", PW'(irq), PW'(1'b0));

    // Edge landing on the same edge as its W1C: set wins
    bus(1'b0, 1'b1, 4'd11, 32'h3);
    idle(); pio_in[65] = 1'b1;
    repeat (4) idle();
    bus(1'b0, 1'b1, 4'd10, 32'h2);
    idle();
    #1 check("set_wins_irq", PW'(irq), PW'(1'b1));
    bus(1'b1, 1'b0, 4'd10, '0);
    idle();
    #1 check("set_wins_cap", PW'(avs_readdata), PW'(32'h2));

    // Channel 3 does not exist: writes dropped, reads zero
    bus(1'b0, 1'b1, 4'd13, 32'hDEAD_BEEF);
    bus(1'b1, 1'b1, 4'd15, 32'hFFFF_FFFF);
    bus(1'b1, 1'b0, 4'd13, '0);
    bus(1'b1, 1'b0, 4'd12, '0);
    idle();
    #1 check("ch3_no_write", pio_out, {32'h0, 32'hA5, 32'h0});
    check("ch3_read_zero", PW'(avs_readdata), '0);

    // Randomised traffic and inputs
    for (int unsigned i = 0; i < 500; i++) begin
      a  = AW'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      bus(op[0], op[1], a, $urandom);
      for (int unsigned c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 7) == 0) pio_in[c*DATA_W +: DATA_W] = $urandom;
    end

    // Reset in the middle of a debounce window
    idle(); pio_in = '1;
    repeat (2) idle();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_pio_out", pio_out, '0);
    check("midrst_irq", PW'(irq), '0);
    check("midrst_readdata", PW'(avs_readdata), '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) idle();
    bus(1'b1, 1'b0, 4'd0, '0);
    bus(1'b1, 1'b0, 4'd0, '0);
    bus(1'b1, 1'b0, 4'd4, '0);
    bus(1'b1, 1'b0, 4'd8, '0);
    #1 check("midrst_data_in", PW'(avs_readdata), PW'(32'hFFFF_FFFF));
    bus(1'b1, 1'b0, 4'd2, '0);
    idle();
    #1 check("midrst_edge_cap", PW'(avs_readdata), PW'(32'hFFFF_FFFF));
    check("midrst_irq_masked", PW'(irq), '0);

    repeat (3) idle();
    #1 check("queue_drained", PW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
